fmap_rd_resp: RTL and testbench



---
 rtl/fmap_rd_resp_pkg.sv | 25 ++
 rtl/fmap_rd_resp_if.sv | 24 ++
 rtl/fmap_rd_resp_fifo.sv | 75 +++++++
 rtl/fmap_rd_resp.sv | 206 ++++++++++++++++++++
 tb/tb_fmap_rd_resp.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmap_rd_resp_pkg.sv
// Shared types and helpers for the feature-map read responder.
// Burst length is decoded once here so queue and counters agree on the clamp.
package fmap_rd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_t;

    localparam int MAX_BURST_DEF  = 32;
    localparam int MAX_BURST_LOG2 = $clog2(MAX_BURST_DEF);

    function automatic logic burst_too_long(input logic [3:0] burst, input int max_log2);
        return int'(burst) > max_log2;
    endfunction

    // Out-of-range burst codes are clamped to the largest legal burst.
    function automatic int unsigned burst_len(input logic [3:0] burst, input int max_log2);
        if (burst_too_long(burst, max_log2)) begin
            return 32'd1 << max_log2;
        end
        return 32'd1 << burst;
    endfunction

endpackage

// File: rtl/fmap_rd_resp_if.sv
// Request (ar*) and beat (r*) channels between the address generator and the responder.
interface fmap_rd_resp_if #(
    parameter int AW = 32,
    parameter int DW = 16
) ();
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic [3:0]    arburst;
    logic          arready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic          rlast;

    modport master (
        output araddr, arvalid, arburst, rready,
        input  arready, rdata, rvalid, rlast
    );

    modport slave (
        input  araddr, arvalid, arburst, rready,
        output arready, rdata, rvalid, rlast
    );
endinterface

// File: rtl/fmap_rd_resp_fifo.sv
// Small synchronous FIFO with registered full/empty flags.
// A push while full is accepted only when a pop happens on the same edge.
module rd_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          full_reg;
    logic          empty_reg;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop & ~empty_reg;
    assign do_push = push & (~full_reg | do_pop);

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_next;
            full_reg  <= (count_next == CW'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    assign dout  = mem_reg[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;
endmodule

// File: rtl/fmap_rd_resp.sv
// Feature-map read responder: queues one-cycle burst requests, reads SRAM word by
// word and returns each burst as a valid/ready beat stream with a last flag.
module fmap_rd_resp
    import fmap_rd_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 16,
    parameter int MEM_AW    = 16,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int AQ_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    fmap_rd_resp_if.slave     rd,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DW-1:0]     mem_rdata,
    output logic              busy,
    output logic              ar_ovf,
    output logic              ar_len_err
);
    localparam int LG = $clog2(MAX_BURST);
    localparam int BW = (LG > 0) ? LG : 1;
    localparam int QW = AW + BW;
    localparam int OW = DW + 1;

    rd_state_t     state_reg;
    rd_state_t     state_next;
    logic [AW-1:0] addr_cnt_reg;
    logic [BW-1:0] beat_cnt_reg;
    logic [1:0]    credit_reg;
    logic          inflight_reg;
    logic          inflight_last_reg;
    logic          ar_ovf_reg;
    logic          ar_len_err_reg;

    logic          q_push;
    logic          q_pop;
    logic          q_full;
    logic          q_empty;
    logic [QW-1:0] q_din;
    logic [QW-1:0] q_dout;
    logic [BW-1:0] req_len_m1;
    logic [AW-1:0] head_addr;
    logic [BW-1:0] head_len_m1;

    logic          issue;
    logic          last_issue;

    logic          ob_push;
    logic          ob_pop;
    logic          ob_full;
    logic          ob_empty;
    logic [OW-1:0] ob_din;
    logic [OW-1:0] ob_dout;
    logic          bypass;
    logic          rvalid_int;
    logic          beat_taken;
    logic [DW-1:0] rdata_int;
    logic          rlast_int;

    // Queue entries hold length-1 so the beat counter loads directly.
    assign req_len_m1  = BW'(burst_len(rd.arburst, LG) - 32'd1);
    assign q_din       = {rd.araddr, req_len_m1};
    assign head_addr   = q_dout[QW-1:BW];
    assign head_len_m1 = q_dout[BW-1:0];
    // A request is also taken when the full queue is popped on the same edge.
    assign q_push      = rd.arvalid & (~q_full | q_pop);
    assign rd.arready  = ~q_full;

    rd_fifo #(
        .DEPTH (AQ_DEPTH),
        .W     (QW)
    ) u_req_q (
        .clk   (clk),
        .rst   (rst),
        .push  (q_push),
        .din   (q_din),
        .pop   (q_pop),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        q_pop      = 1'b0;
        issue      = (state_reg == BURST) && (credit_reg < 2'd2);
        last_issue = issue && (beat_cnt_reg == '0);
        case (state_reg)
            IDLE: begin
                if (!q_empty) begin
                    q_pop      = 1'b1;
                    state_next = BURST;
                end
            end
            BURST: begin
                if (last_issue) begin
                    if (!q_empty) begin
                        q_pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt_reg <= '0;
            beat_cnt_reg <= '0;
        end else if (q_pop) begin
            addr_cnt_reg <= head_addr;
            beat_cnt_reg <= head_len_m1;
        end else if (issue) begin
            addr_cnt_reg <= addr_cnt_reg + 1'b1;
            beat_cnt_reg <= beat_cnt_reg - 1'b1;
        end
    end

    assign mem_en   = issue;
    assign mem_addr = addr_cnt_reg[MEM_AW-1:0];

    // Credits count beats issued to SRAM but not yet handed downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_reg        <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            inflight_reg      <= issue;
            inflight_last_reg <= last_issue;
            case ({issue, beat_taken})
                2'b10:   credit_reg <= credit_reg + 1'b1;
                2'b01:   credit_reg <= credit_reg - 1'b1;
                default: credit_reg <= credit_reg;
            endcase
        end
    end

    // SRAM data goes straight out when the buffer is empty and downstream is ready.
    assign rvalid_int = ~ob_empty | inflight_reg;
    assign beat_taken = rvalid_int & rd.rready;
    assign bypass     = inflight_reg & ob_empty & rd.rready;
    assign ob_push    = inflight_reg & ~bypass & ~ob_full;
    assign ob_pop     = ~ob_empty & rd.rready;
    assign ob_din     = {mem_rdata, inflight_last_reg};

    rd_fifo #(
        .DEPTH (2),
        .W     (OW)
    ) u_out_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (ob_push),
        .din   (ob_din),
        .pop   (ob_pop),
        .dout  (ob_dout),
        .full  (ob_full),
        .empty (ob_empty)
    );

    always_comb begin
        rdata_int = '0;
        rlast_int = 1'b0;
        if (!ob_empty) begin
            rdata_int = ob_dout[OW-1:1];
            rlast_int = ob_dout[0];
        end else if (inflight_reg) begin
            rdata_int = mem_rdata;
            rlast_int = inflight_last_reg;
        end
    end

    assign rd.rvalid = rvalid_int;
    assign rd.rdata  = rdata_int;
    assign rd.rlast  = rlast_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_ovf_reg     <= 1'b0;
            ar_len_err_reg <= 1'b0;
        end else begin
            if (rd.arvalid && !q_push) begin
                ar_ovf_reg <= 1'b1;
            end
            if (rd.arvalid && burst_too_long(rd.arburst, LG)) begin
                ar_len_err_reg <= 1'b1;
            end
        end
    end

    assign ar_ovf     = ar_ovf_reg;
    assign ar_len_err = ar_len_err_reg;
    assign busy       = ~q_empty | (state_reg == BURST) | rvalid_int;
endmodule

// File: tb/tb_fmap_rd_resp.sv
// Bench for fmap_rd_resp: directed scenarios plus randomized requests and backpressure,
// checked against a queue of expected beats built from the burst rules.
module tb_fmap_rd_resp;
    localparam int AW     = 32;
    localparam int DW     = 16;
    localparam int MEM_AW = 16;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_en;
    logic [MEM_AW-1:0] mem_addr;
    logic [DW-1:0]     mem_rdata = '0;
    logic              busy;
    logic              ar_ovf;
    logic              ar_len_err;

    fmap_rd_resp_if #(.AW(AW), .DW(DW)) rd ();

    fmap_rd_resp #(
        .AW        (AW),
        .DW        (DW),
        .MEM_AW    (MEM_AW),
        .MAX_BURST (32),
        .AQ_DEPTH  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd         (rd),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .ar_ovf     (ar_ovf),
        .ar_len_err (ar_len_err)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    beat_t exp_q[$];
    int    beats_seen  = 0;
    int    outstanding = 0;
    int    rr_mode     = 0;
    int    rr_cyc      = 0;
    bit    hold_valid  = 0;
    logic [16:0] hold_val;

    function automatic logic [15:0] sram_word(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // SRAM with one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= sram_word(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic add_burst(input logic [31:0] addr, input int burst);
        int len;
        len = (burst > 5) ? 32 : (1 << burst);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.data = sram_word(addr[15:0] + 16'(i));
            b.last = (i == len - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request strobe for a single cycle; called just after a rising edge.
    task automatic send(input logic [31:0] addr, input int burst, input bit accept);
        rd.araddr  = addr;
        rd.arburst = 4'(burst);
        rd.arvalid = 1'b1;
        if (accept) add_burst(addr, burst);
        $display("req addr=0x%08h burst=%0d accept=%0d", addr, burst, accept);
        tick();
        rd.arvalid = 1'b0;
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            @(posedge clk);
            k++;
        end
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // rready patterns: 0 always, 1 = 1,0,0,1 cycle, 2 never, 3 random
    initial begin
        rd.rready = 1'b0;
        forever begin
            tick();
            rr_cyc++;
            case (rr_mode)
                0:       rd.rready = 1'b1;
                1:       rd.rready = (rr_cyc % 4 == 0) || (rr_cyc % 4 == 3);
                2:       rd.rready = 1'b0;
                default: rd.rready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Beat monitor: data order, last flag, hold-under-stall and credit limit.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                outstanding = 0;
                hold_valid  = 0;
            end else begin
                if (mem_en) check("credit", 32'(outstanding < 2), 32'd1);
                if (hold_valid) begin
                    check("hold_valid", 32'(rd.rvalid), 32'd1);
                    check("hold_data", 32'({rd.rlast, rd.rdata}), 32'(hold_val));
                end
                if (rd.rvalid && rd.rready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 32'(rd.rdata), 32'hFFFF_FFFF);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("rdata", 32'(rd.rdata), 32'(e.data));
                        check("rlast", 32'(rd.rlast), 32'(e.last));
                    end
                    beats_seen++;
                end
                hold_valid  = rd.rvalid && !rd.rready;
                hold_val    = {rd.rlast, rd.rdata};
                outstanding = outstanding + (mem_en ? 1 : 0) - ((rd.rvalid && rd.rready) ? 1 : 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got_addr[$];
        logic [15:0] wrap_exp[4];
        int k;
        int start;
        wrap_exp[0] = 16'hFFFE;
        wrap_exp[1] = 16'hFFFF;
        wrap_exp[2] = 16'h0000;
        wrap_exp[3] = 16'h0001;
        rd.araddr  = '0;
        rd.arburst = '0;
        rd.arvalid = 1'b0;

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_arready", 32'(rd.arready), 32'd1);
        check("rst_rvalid", 32'(rd.rvalid), 32'd0);
        check("rst_rlast", 32'(rd.rlast), 32'd0);
        check("rst_rdata", 32'(rd.rdata), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ar_ovf), 32'd0);
        check("rst_len_err", 32'(ar_len_err), 32'd0);

        // Single burst and request-to-beat latency
        tick();
        send(32'h40, 2, 1);
        @(negedge clk);
        check("lat_n1_rvalid", 32'(rd.rvalid), 32'd0);
        @(negedge clk);
        check("lat_n2_mem_en", 32'(mem_en), 32'd1);
        check("lat_n2_mem_addr", 32'(mem_addr), 32'h40);
        check("lat_n2_rvalid", 32'(rd.rvalid), 32'd0);
        @(negedge clk);
        check("lat_n3_rvalid", 32'(rd.rvalid), 32'd1);
        drain("single", 50);

        // Back-to-back bursts must stream without a gap
        tick();
        send(32'h0, 5, 1);
        tick();
        send(32'h100, 5, 1);
        k = 0;
        @(negedge clk);
        while (!rd.rvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("b2b_first", 32'(rd.rvalid), 32'd1);
        repeat (63) begin
            @(negedge clk);
            check("b2b_valid", 32'(rd.rvalid), 32'd1);
        end
        drain("b2b", 200);

        // Backpressure
        rr_mode = 1;
        tick();
        send(32'h2000, 5, 1);
        drain("bp", 500);
        check("pre_ovf", 32'(ar_ovf), 32'd0);
        check("pre_len_err", 32'(ar_len_err), 32'd0);

        // Overflow: the popped burst plus a 2-deep queue absorb three strobes
        rr_mode = 2;
        tick();
        tick();
        send(32'h600, 2, 1);
        send(32'h700, 2, 1);
        send(32'h800, 2, 1);
        send(32'h900, 2, 0);
        check("ovf_flag", 32'(ar_ovf), 32'd1);
        check("ovf_arready", 32'(rd.arready), 32'd0);
        rr_mode = 0;
        drain("ovf", 200);

        // SRAM address wrap
        tick();
        send(32'h0000FFFE, 2, 1);
        k = 0;
        while (got_addr.size() < 4 && k < 20) begin
            @(negedge clk);
            if (mem_en) got_addr.push_back(mem_addr);
            k++;
        end
        check("wrap_count", 32'(got_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
            check("wrap_addr", 32'(got_addr[i]), 32'(wrap_exp[i]));
        end
        drain("wrap", 50);

        // Length clamp
        tick();
        send(32'h1234_0500, 7, 1);
        drain("clamp", 200);
        check("len_err", 32'(ar_len_err), 32'd1);

        // Reset in the middle of a burst
        tick();
        send(32'h3000, 5, 1);
        start = beats_seen;
        k = 0;
        while (beats_seen - start < 10 && k < 100) begin
            @(posedge clk);
            k++;
        end
        check("rst_mid_reached", 32'(beats_seen - start >= 10), 32'd1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_rvalid", 32'(rd.rvalid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ovf", 32'(ar_ovf), 32'd0);
        repeat (5) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(rd.rvalid), 32'd0);
        end
        tick();
        send(32'h4000, 3, 1);
        drain("post_rst", 100);

        // Randomized requests under random backpressure
        rr_mode = 3;
        for (int n = 0; n < 30; n++) begin
            tick();
            k = 0;
            while (!rd.arready && k < 200) begin
                tick();
                k++;
            end
            check("rand_arready", 32'(rd.arready), 32'd1);
            send($urandom, int'($urandom_range(0, 7)), 1);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain("rand", 20000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
